// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM state codes, the enumeration
// built on them, and the bundle of enable/flush controls with its RUN-mode rules.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_CODE_RUN      = 2'd0;
    localparam logic [1:0] ST_CODE_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_CODE_ERROR    = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN      = ST_CODE_RUN,
        ST_MEM_WAIT = ST_CODE_MEM_WAIT,
        ST_ERROR    = ST_CODE_ERROR
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    // Everything frozen, no bubbles inserted.
    localparam ctrl_t CTRL_HOLD = ctrl_t'(7'b0000000);

    // Normal-flow control: a taken branch squashes both younger stages and wins
    // over a load-use stall; a load-use stall freezes PC and IF/ID and drops a
    // bubble into ID/EX.
    function automatic ctrl_t run_ctrl(input logic branch_taken, input logic hazard);
        if (branch_taken) return ctrl_t'(7'b1111111);
        if (hazard)       return ctrl_t'(7'b0011101);
        return ctrl_t'(7'b1111100);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: hazard/memory status in, stage enables and flushes out.
interface pipe_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] ex_rt;
    logic             ex_memread;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       state_o;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, ex_rt, ex_memread, ex_branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
        input  state_o, mem_err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_rt, ex_memread, ex_branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
        output state_o, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the instruction
// in ID. Register 0 is hard-wired zero and never creates a dependency.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_memread,
    output logic             hazard
);
    assign hazard = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: RUN / MEM_WAIT / ERROR FSM, memory-wait timeout counter,
// saturating stall counter and the priority mux for stage enables and flushes.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic      clk,
    input  logic      reset,
    pipe_ctrl_if.slave bus
);

    // Last wait count tolerated before the access is declared dead.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_nxt_wait;
    logic [CNT_W-1:0] r_stall_cnt;
    ctrl_t            w_ctrl;
    ctrl_t            w_ctrl_gated;
    logic             w_hazard;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .ex_rt      (bus.ex_rt),
        .ex_memread (bus.ex_memread),
        .hazard     (w_hazard)
    );

    // Next state, next wait count and same-cycle control outputs.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_wait  = r_wait_cnt;
        w_ctrl      = CTRL_HOLD;
        case (r_state)
            ST_RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    w_nxt_state = ST_MEM_WAIT;
                    w_nxt_wait  = 8'd1;
                end else begin
                    w_ctrl = run_ctrl(bus.ex_branch_taken, w_hazard);
                end
            end
            ST_MEM_WAIT: begin
                if (!bus.mem_ready) begin
                    w_nxt_wait = r_wait_cnt + 8'd1;
                    if (r_wait_cnt == TIMEOUT_LAST) w_nxt_state = ST_ERROR;
                end else begin
                    w_ctrl      = run_ctrl(bus.ex_branch_taken, w_hazard);
                    w_nxt_state = ST_RUN;
                    w_nxt_wait  = 8'd0;
                end
            end
            ST_ERROR: w_nxt_state = ST_ERROR;
            default:  w_nxt_state = ST_ERROR;
        endcase
        // Reset holds the whole pipeline frozen whatever the state or inputs.
        w_ctrl_gated = reset ? w_ctrl : CTRL_HOLD;
    end

    // State, wait counter and stall counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= 8'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_wait_cnt <= w_nxt_wait;
            if (!w_ctrl_gated.pc_en) r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign bus.pc_en      = w_ctrl_gated.pc_en;
    assign bus.ifid_en    = w_ctrl_gated.ifid_en;
    assign bus.idex_en    = w_ctrl_gated.idex_en;
    assign bus.exmem_en   = w_ctrl_gated.exmem_en;
    assign bus.memwb_en   = w_ctrl_gated.memwb_en;
    assign bus.ifid_flush = w_ctrl_gated.ifid_flush;
    assign bus.idex_flush = w_ctrl_gated.idex_flush;
    assign bus.state_o    = r_state;
    assign bus.mem_err    = (r_state == ST_ERROR);
    assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (default parameters, and a short-timeout /
// narrow-counter variant) share one stimulus stream and are compared each cycle
// against a behavioural model, plus directed scenario checks.
module tb_pipe_ctrl;

    localparam int REG_W = 5;
    localparam int TO_A  = 16;
    localparam int CW_A  = 16;
    localparam int TO_B  = 3;
    localparam int CW_B  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.REG_W(REG_W), .CNT_W(CW_A)) ifa ();
    pipe_ctrl_if #(.REG_W(REG_W), .CNT_W(CW_B)) ifb ();

    assign ifb.id_rs           = ifa.id_rs;
    assign ifb.id_rt           = ifa.id_rt;
    assign ifb.ex_rt           = ifa.ex_rt;
    assign ifb.ex_memread      = ifa.ex_memread;
    assign ifb.ex_branch_taken = ifa.ex_branch_taken;
    assign ifb.mem_req         = ifa.mem_req;
    assign ifb.mem_ready       = ifa.mem_ready;

    pipe_ctrl #(.REG_W(REG_W), .TIMEOUT(TO_A), .CNT_W(CW_A)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifa)
    );

    pipe_ctrl #(.REG_W(REG_W), .TIMEOUT(TO_B), .CNT_W(CW_B)) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model, one slot per instance: number of consecutive cycles
    // the current memory access has been outstanding, whether it has timed out,
    // and how many frozen-PC cycles have been seen.
    int to_p   [2] = '{TO_A, TO_B};
    int max_p  [2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
    int m_wait [2];
    bit m_err  [2];
    int m_stall[2];

    // Expected {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush}.
    function automatic logic [6:0] exp_ctrl(input int k);
        logic lu;
        lu = ifa.ex_memread && (ifa.ex_rt != 0) &&
             ((ifa.ex_rt == ifa.id_rs) || (ifa.ex_rt == ifa.id_rt));
        if (!rst_n)                                    return 7'b0000000;
        if (m_err[k])                                  return 7'b0000000;
        if (!ifa.mem_ready && (m_wait[k] > 0))         return 7'b0000000;
        if (!ifa.mem_ready && ifa.mem_req)             return 7'b0000000;
        if (ifa.ex_branch_taken)                       return 7'b1111111;
        if (lu)                                        return 7'b0011101;
        return 7'b1111100;
    endfunction

    function automatic logic [25:0] exp_vec(input int k);
        logic [1:0] st;
        st = m_err[k] ? 2'd2 : ((m_wait[k] > 0) ? 2'd1 : 2'd0);
        return {exp_ctrl(k), st, m_err[k], 16'(m_stall[k])};
    endfunction

    function automatic logic [25:0] obs_vec(input int k);
        if (k == 0)
            return {ifa.pc_en, ifa.ifid_en, ifa.idex_en, ifa.exmem_en, ifa.memwb_en,
                    ifa.ifid_flush, ifa.idex_flush, ifa.state_o, ifa.mem_err, ifa.stall_cnt};
        return {ifb.pc_en, ifb.ifid_en, ifb.idex_en, ifb.exmem_en, ifb.memwb_en,
                ifb.ifid_flush, ifb.idex_flush, ifb.state_o, ifb.mem_err, 16'(ifb.stall_cnt)};
    endfunction

    task automatic model_tick();
        for (int k = 0; k < 2; k++) begin
            logic [6:0] c;
            c = exp_ctrl(k);
            if (!rst_n) begin
                m_wait[k] = 0; m_err[k] = 0; m_stall[k] = 0;
            end else begin
                if (!c[6] && (m_stall[k] < max_p[k])) m_stall[k]++;
                if (!m_err[k]) begin
                    if (ifa.mem_ready)      m_wait[k] = 0;
                    else if (m_wait[k] > 0) m_wait[k]++;
                    else if (ifa.mem_req)   m_wait[k] = 1;
                    if (m_wait[k] >= to_p[k]) begin
                        m_err[k]  = 1;
                        m_wait[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic set_in(input int rs, input int rt, input int ert, input bit mr,
                          input bit br, input bit req, input bit rdy);
        ifa.id_rs           = REG_W'(rs);
        ifa.id_rt           = REG_W'(rt);
        ifa.ex_rt           = REG_W'(ert);
        ifa.ex_memread      = mr;
        ifa.ex_branch_taken = br;
        ifa.mem_req         = req;
        ifa.mem_ready       = rdy;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        adv();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_in($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (c > 0) begin
                n_checks++;
                if ({ifa.state_o, ifa.mem_err, ifa.stall_cnt} !== 19'd0) begin
                    n_fail++;
                    $display("FAIL reset_regs cyc%0d got=%h want=0", c,
                             {ifa.state_o, ifa.mem_err, ifa.stall_cnt});
                end
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k)[25:19] !== 7'd0) begin
                    n_fail++;
                    $display("FAIL reset_ctrl dut%0d cyc%0d got=%b want=0000000", k, c, obs_vec(k)[25:19]);
                end
            end
            adv();
        end
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL reset_release dut%0d got=%h want=%h", k, obs_vec(k), exp_vec(k));
            end
        end
        adv();
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(5, 9, 5, 1, 0, 0, 0);
        n_checks++;
        if ({ifa.pc_en, ifa.ifid_en, ifa.idex_flush} !== 3'b001) begin
            n_fail++;
            $display("FAIL load_use_ctrl got=%b want=001", {ifa.pc_en, ifa.ifid_en, ifa.idex_flush});
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL load_use dut%0d got=%h want=%h", k, obs_vec(k), exp_vec(k));
            end
        end
        adv();
        set_in(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (ifa.stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL load_use_stall_cnt got=%0d want=1", ifa.stall_cnt);
        end
        adv();
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_in(0, 0, 0, 1, 0, 0, 0);
        n_checks++;
        if (obs_vec(0)[25:19] !== 7'b1111100) begin
            n_fail++;
            $display("FAIL zero_reg got=%b want=1111100", obs_vec(0)[25:19]);
        end
        adv();
        n_checks++;
        if (ifa.stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL zero_reg_stall got=%0d want=0", ifa.stall_cnt);
        end
    endtask

    task automatic test_branch_over_load_use();
        do_reset();
        set_in(7, 3, 7, 1, 1, 0, 0);
        n_checks++;
        if (obs_vec(0)[25:19] !== 7'b1111111) begin
            n_fail++;
            $display("FAIL branch_load_use got=%b want=1111111", obs_vec(0)[25:19]);
        end
        adv();
        set_in(2, 3, 3, 1, 0, 0, 0);
        n_checks++;
        if (obs_vec(0)[25:19] !== 7'b0011101) begin
            n_fail++;
            $display("FAIL load_use_rt got=%b want=0011101", obs_vec(0)[25:19]);
        end
        adv();
    endtask

    task automatic test_mem_wait();
        logic [6:0] want_ctrl;
        logic [1:0] want_st;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c < 3)       set_in(1, 2, 3, 0, 0, 1, 0);
            else if (c == 3) set_in(1, 2, 3, 0, 0, 1, 1);
            else             set_in(0, 0, 0, 0, 0, 0, 0);
            want_ctrl = (c < 3) ? 7'b0000000 : 7'b1111100;
            want_st   = (c == 0 || c == 4) ? 2'd0 : 2'd1;
            n_checks++;
            if ({ifa.pc_en, ifa.ifid_en, ifa.idex_en, ifa.exmem_en, ifa.memwb_en,
                 ifa.ifid_flush, ifa.idex_flush, ifa.state_o} !== {want_ctrl, want_st}) begin
                n_fail++;
                $display("FAIL mem_wait cyc%0d got=%b/%0d want=%b/%0d", c,
                         obs_vec(0)[25:19], ifa.state_o, want_ctrl, want_st);
            end
            if (c == 4) begin
                n_checks++;
                if (ifa.stall_cnt !== 16'd3) begin
                    n_fail++;
                    $display("FAIL mem_wait_stall got=%0d want=3", ifa.stall_cnt);
                end
            end
            adv();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c < TO_A; c++) begin
            set_in(0, 0, 0, 0, 0, 1, 0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL timeout_wait dut%0d cyc%0d got=%h want=%h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            adv();
        end
        for (int c = 0; c < 4; c++) begin
            set_in(0, 0, 0, 0, 1'($urandom), 1'($urandom), 1);
            n_checks++;
            if ({ifa.state_o, ifa.mem_err, ifa.pc_en, ifa.ifid_flush} !== 5'b10100) begin
                n_fail++;
                $display("FAIL timeout_error cyc%0d got=%b want=10100", c,
                         {ifa.state_o, ifa.mem_err, ifa.pc_en, ifa.ifid_flush});
            end
            adv();
        end
        n_checks++;
        if (ifb.stall_cnt !== 3'd7) begin
            n_fail++;
            $display("FAIL stall_saturate got=%0d want=7", ifb.stall_cnt);
        end
    endtask

    task automatic test_reset_in_error();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (ifa.pc_en !== 1'b0 || ifa.mem_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_reset_low got=%b%b want=01", ifa.pc_en, ifa.mem_err);
        end
        adv();
        n_checks++;
        if ({ifa.state_o, ifa.mem_err, ifa.stall_cnt, ifa.pc_en} !== 20'd0) begin
            n_fail++;
            $display("FAIL err_reset_edge got=%h want=0", {ifa.state_o, ifa.mem_err, ifa.stall_cnt, ifa.pc_en});
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k) || obs_vec(k)[25:19] !== 7'b1111100) begin
                n_fail++;
                $display("FAIL err_reset_release dut%0d got=%h want=%h", k, obs_vec(k), exp_vec(k));
            end
        end
        adv();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst_n = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), ($urandom_range(0, 99) < 15),
                   ($urandom_range(0, 99) < 25), 1'($urandom));
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d got=%h want=%h", k, c, obs_vec(k), exp_vec(k));
                end
            end
            adv();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 0; m_err[k] = 0; m_stall[k] = 0;
        end
        @(negedge clk);
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_over_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_in_error();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
